// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: FSM encoding and byte-lane selectors.
package mem_access_stage_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StRmwRd,
    StRmwWr
  } state_e;

  localparam logic BYTE_LO = 1'b0;
  localparam logic BYTE_HI = 1'b1;

endpackage

// File: rtl/mem_byte_lane.sv
// Little-endian byte lane helper: zero-extended byte extract and byte merge into a word.
module mem_byte_lane
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [7:0]        i_byte,
  input  logic              i_lane,
  output logic [DATA_W-1:0] o_zext,
  output logic [DATA_W-1:0] o_merged
);

  always_comb begin
    o_zext   = '0;
    o_merged = i_word;
    if (i_lane == BYTE_HI) begin
      o_zext[7:0]    = i_word[15:8];
      o_merged[15:8] = i_byte;
    end else begin
      o_zext[7:0]    = i_word[7:0];
      o_merged[7:0]  = i_byte;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: ALU pass-through, word/byte loads and read-modify-write byte stores over a
// req/ack data bus, with upstream stall, ack timeout and a registered writeback slot.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_ex_valid,
  input  logic [DATA_W-1:0] i_ex_alu_out,
  input  logic [DATA_W-1:0] i_ex_store_data,
  input  logic [3:0]        i_ex_wreg_loc,
  input  logic              i_ex_wreg_en,
  input  logic              i_ex_mem_to_reg,
  input  logic              i_ex_mem_read,
  input  logic              i_ex_mem_write,
  input  logic              i_ex_byte,
  output logic              o_stall,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-2:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  input  logic              i_dmem_ack,
  output logic              o_wb_valid,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [3:0]        o_wb_loc,
  output logic              o_wb_en,
  output logic              o_bus_err
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  state_e            r_state, w_state_d;
  logic              r_req, w_req_d, r_we, w_we_d;
  logic [ADDR_W-2:0] r_addr, w_addr_d;
  logic [DATA_W-1:0] r_wdata, w_wdata_d, r_alu, w_alu_d;
  logic              r_lane, w_lane_d, r_byte, w_byte_d, r_m2r, w_m2r_d;
  logic [3:0]        r_loc, w_loc_d;
  logic              r_wen, w_wen_d, r_flushed, w_flushed_d, r_bus_err, w_bus_err_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              r_wb_valid, w_wb_valid_d, r_wb_en, w_wb_en_d;
  logic [DATA_W-1:0] r_wb_data, w_wb_data_d;
  logic [3:0]        r_wb_loc, w_wb_loc_d;

  logic              w_ack, w_timeout, w_final_ack, w_accept_mem;
  logic [DATA_W-1:0] w_zext, w_merged;

  mem_byte_lane #(
    .DATA_W(DATA_W)
  ) u_byte_lane (
    .i_word  (i_dmem_rdata),
    .i_byte  (r_wdata[7:0]),
    .i_lane  (r_lane),
    .o_zext  (w_zext),
    .o_merged(w_merged)
  );

  always_comb begin
    w_state_d    = r_state;
    w_req_d      = r_req;
    w_we_d       = r_we;
    w_addr_d     = r_addr;
    w_wdata_d    = r_wdata;
    w_alu_d      = r_alu;
    w_lane_d     = r_lane;
    w_byte_d     = r_byte;
    w_m2r_d      = r_m2r;
    w_loc_d      = r_loc;
    w_wen_d      = r_wen;
    w_flushed_d  = r_flushed;
    w_bus_err_d  = r_bus_err;
    w_cnt_d      = r_cnt;
    w_wb_valid_d = 1'b0;
    w_wb_en_d    = 1'b0;
    w_wb_data_d  = r_wb_data;
    w_wb_loc_d   = r_wb_loc;
    w_accept_mem = 1'b0;

    // Spurious acks (no request outstanding) are dropped here.
    w_ack       = i_dmem_ack & r_req;
    w_timeout   = r_req & ~i_dmem_ack & (ACK_TIMEOUT != 0) & (r_cnt == CNT_LAST);
    w_final_ack = w_ack & ((r_state == StRd) | (r_state == StWr) | (r_state == StRmwWr));

    if (r_req & ~i_dmem_ack) w_cnt_d = r_cnt + CNT_W'(1);
    if (i_flush && r_state == StRd) w_flushed_d = 1'b1;

    unique case (r_state)
      StIdle: begin
        if (i_ex_valid && !i_flush) begin
          w_addr_d    = i_ex_alu_out[ADDR_W-1:1];
          w_lane_d    = i_ex_alu_out[0];
          w_alu_d     = i_ex_alu_out;
          w_wdata_d   = i_ex_store_data;
          w_loc_d     = i_ex_wreg_loc;
          w_wen_d     = i_ex_wreg_en;
          w_byte_d    = i_ex_byte;
          w_m2r_d     = i_ex_mem_to_reg;
          w_flushed_d = 1'b0;
          w_cnt_d     = '0;
          if (i_ex_mem_write) begin
            w_state_d    = i_ex_byte ? StRmwRd : StWr;
            w_req_d      = 1'b1;
            w_we_d       = ~i_ex_byte;
            w_accept_mem = 1'b1;
          end else if (i_ex_mem_read) begin
            w_state_d    = StRd;
            w_req_d      = 1'b1;
            w_we_d       = 1'b0;
            w_accept_mem = 1'b1;
          end else begin
            w_wb_valid_d = 1'b1;
            w_wb_en_d    = i_ex_wreg_en;
            w_wb_data_d  = i_ex_alu_out;
            w_wb_loc_d   = i_ex_wreg_loc;
          end
        end
      end
      StRd: begin
        if (w_ack) begin
          w_state_d    = StIdle;
          w_req_d      = 1'b0;
          w_wb_valid_d = 1'b1;
          w_wb_en_d    = r_wen & ~r_flushed & ~i_flush;
          w_wb_loc_d   = r_loc;
          w_wb_data_d  = r_m2r ? (r_byte ? w_zext : i_dmem_rdata) : r_alu;
        end
      end
      StRmwRd: begin
        // Second bus access starts immediately with the merged word.
        if (w_ack) begin
          w_state_d = StRmwWr;
          w_we_d    = 1'b1;
          w_wdata_d = w_merged;
          w_cnt_d   = '0;
        end
      end
      StWr, StRmwWr: begin
        if (w_ack) begin
          w_state_d    = StIdle;
          w_req_d      = 1'b0;
          w_we_d       = 1'b0;
          w_wb_valid_d = 1'b1;
          w_wb_loc_d   = r_loc;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_timeout) begin
      w_state_d    = StIdle;
      w_req_d      = 1'b0;
      w_we_d       = 1'b0;
      w_bus_err_d  = 1'b1;
      w_wb_valid_d = 1'b0;
      w_wb_en_d    = 1'b0;
    end

    o_stall = ((r_state != StIdle) & ~(w_final_ack | w_timeout)) | w_accept_mem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_alu      <= '0;
      r_lane     <= 1'b0;
      r_byte     <= 1'b0;
      r_m2r      <= 1'b0;
      r_loc      <= '0;
      r_wen      <= 1'b0;
      r_flushed  <= 1'b0;
      r_bus_err  <= 1'b0;
      r_cnt      <= '0;
      r_wb_valid <= 1'b0;
      r_wb_en    <= 1'b0;
      r_wb_data  <= '0;
      r_wb_loc   <= '0;
    end else begin
      r_state    <= w_state_d;
      r_req      <= w_req_d;
      r_we       <= w_we_d;
      r_addr     <= w_addr_d;
      r_wdata    <= w_wdata_d;
      r_alu      <= w_alu_d;
      r_lane     <= w_lane_d;
      r_byte     <= w_byte_d;
      r_m2r      <= w_m2r_d;
      r_loc      <= w_loc_d;
      r_wen      <= w_wen_d;
      r_flushed  <= w_flushed_d;
      r_bus_err  <= w_bus_err_d;
      r_cnt      <= w_cnt_d;
      r_wb_valid <= w_wb_valid_d;
      r_wb_en    <= w_wb_en_d;
      r_wb_data  <= w_wb_data_d;
      r_wb_loc   <= w_wb_loc_d;
    end
  end

  assign o_dmem_req   = r_req;
  assign o_dmem_we    = r_we;
  assign o_dmem_addr  = r_addr;
  assign o_dmem_wdata = r_wdata;
  assign o_wb_valid   = r_wb_valid;
  assign o_wb_en      = r_wb_en;
  assign o_wb_data    = r_wb_data;
  assign o_wb_loc     = r_wb_loc;
  assign o_bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table for single instructions plus hand sequences
// for stall timing, stray ack, flush, timeout and reset mid-access.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0, ex_valid = 1'b0;
  logic [15:0] ex_alu = '0, ex_sdata = '0;
  logic [3:0]  ex_loc = '0;
  logic        ex_wen = 1'b0, ex_m2r = 1'b0, ex_rd = 1'b0, ex_wr = 1'b0, ex_bt = 1'b0;
  logic        stall, dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata, dmem_rdata = '0;
  logic        wb_valid, wb_en, bus_err;
  logic [15:0] wb_data;
  logic [3:0]  wb_loc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(
    .DATA_W     (16),
    .ADDR_W     (16),
    .ACK_TIMEOUT(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_flush        (flush),
    .i_ex_valid     (ex_valid),
    .i_ex_alu_out   (ex_alu),
    .i_ex_store_data(ex_sdata),
    .i_ex_wreg_loc  (ex_loc),
    .i_ex_wreg_en   (ex_wen),
    .i_ex_mem_to_reg(ex_m2r),
    .i_ex_mem_read  (ex_rd),
    .i_ex_mem_write (ex_wr),
    .i_ex_byte      (ex_bt),
    .o_stall        (stall),
    .o_dmem_req     (dmem_req),
    .o_dmem_we      (dmem_we),
    .o_dmem_addr    (dmem_addr),
    .o_dmem_wdata   (dmem_wdata),
    .i_dmem_rdata   (dmem_rdata),
    .i_dmem_ack     (dmem_ack),
    .o_wb_valid     (wb_valid),
    .o_wb_data      (wb_data),
    .o_wb_loc       (wb_loc),
    .o_wb_en        (wb_en),
    .o_bus_err      (bus_err)
  );

  typedef struct {
    logic [15:0] alu;
    logic [15:0] sdata;
    logic [3:0]  loc;
    logic        wen, rd, wr, bt;
    logic [15:0] rdata;
    logic [14:0] e_addr;
    logic [15:0] e_wdata;
    logic        chk_wb;
    logic [15:0] e_wb;
    logic        e_wen;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] alu, input logic [15:0] sd, input logic [3:0] loc,
                       input logic wen, input logic rd, input logic wr, input logic bt);
    ex_alu = alu; ex_sdata = sd; ex_loc = loc; ex_wen = wen;
    ex_rd = rd; ex_wr = wr; ex_bt = bt; ex_m2r = rd; ex_valid = 1'b1;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0; ex_bt = 1'b0; ex_wen = 1'b0;
  endtask

  task automatic wait_req(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dmem_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({nm, " req timeout"}, 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   nacc;
    bit   ok;
    logic exp_we;
    nacc = v.wr ? (v.bt ? 2 : 1) : (v.rd ? 1 : 0);
    drive(v.alu, v.sdata, v.loc, v.wen, v.rd, v.wr, v.bt);
    @(negedge clk);
    chk($sformatf("v%0d stall", idx), stall, (nacc != 0));
    tick();
    idle_ex();
    for (int k = 0; k < nacc; k++) begin
      wait_req($sformatf("v%0d acc%0d", idx, k), ok);
      if (!ok) return;
      exp_we = v.wr & ~(v.bt & (k == 0));
      chk($sformatf("v%0d acc%0d addr", idx, k), dmem_addr, v.e_addr);
      chk($sformatf("v%0d acc%0d we", idx, k), dmem_we, exp_we);
      if (exp_we) chk($sformatf("v%0d wdata", idx), dmem_wdata, v.e_wdata);
      tick();
      dmem_ack = 1'b1; dmem_rdata = v.rdata;
      tick();
      dmem_ack = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("v%0d wb_valid", idx), wb_valid, 1);
    chk($sformatf("v%0d wb_en", idx), wb_en, v.e_wen);
    chk($sformatf("v%0d wb_loc", idx), wb_loc, v.loc);
    if (v.chk_wb) chk($sformatf("v%0d wb_data", idx), wb_data, v.e_wb);
    tick();
    chk($sformatf("v%0d wb_valid pulse", idx), wb_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //        alu       sdata     loc  wen   rd    wr    bt    rdata     e_addr    e_wdata  chk  e_wb  e_wen
    vt[0]  = '{16'h1234, 16'h0000, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 15'h0000, 16'h0000, 1'b1, 16'h1234, 1'b1};
    vt[1]  = '{16'hFFFF, 16'h0000, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 15'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0};
    vt[2]  = '{16'h0010, 16'h0000, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF, 15'h0008, 16'h0000, 1'b1, 16'hBEEF, 1'b1};
    vt[3]  = '{16'h0011, 16'h0000, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1357, 15'h0008, 16'h0000, 1'b1, 16'h1357, 1'b1};
    vt[4]  = '{16'h0020, 16'h0000, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 16'hC3A5, 15'h0010, 16'h0000, 1'b1, 16'h00A5, 1'b1};
    vt[5]  = '{16'h0021, 16'h0000, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1, 16'hC3A5, 15'h0010, 16'h0000, 1'b1, 16'h00C3, 1'b1};
    vt[6]  = '{16'h0040, 16'h5A5A, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 15'h0020, 16'h5A5A, 1'b0, 16'h0000, 1'b0};
    vt[7]  = '{16'h0021, 16'h00AA, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 15'h0010, 16'hAA34, 1'b0, 16'h0000, 1'b0};
    vt[8]  = '{16'h0020, 16'hFF77, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 15'h0010, 16'h1277, 1'b0, 16'h0000, 1'b0};
    vt[9]  = '{16'h0062, 16'h0F0F, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 15'h0031, 16'h0F0F, 1'b0, 16'h0000, 1'b0};
    vt[10] = '{16'h00FF, 16'h0000, 4'd10, 1'b1, 1'b1, 1'b0, 1'b1, 16'h80FF, 15'h007F, 16'h0000, 1'b1, 16'h0080, 1'b1};

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst stall", stall, 0);
    chk("rst req", dmem_req, 0);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_en", wb_en, 0);
    chk("rst wb_data", wb_data, 0);
    chk("rst bus_err", bus_err, 0);
    chk("rst addr", dmem_addr, 0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_vec(vt[i], i);

    // Word load with ack on the third cycle after accept: stall for exactly three cycles.
    n = 0;
    drive(16'h0010, 16'h0000, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); n += int'(stall);
    tick(); idle_ex();
    @(negedge clk); n += int'(stall);
    chk("ld req", dmem_req, 1);
    chk("ld addr", dmem_addr, 15'h0008);
    tick();
    @(negedge clk); n += int'(stall);
    chk("ld addr stable", dmem_addr, 15'h0008);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
    @(negedge clk);
    chk("ld stall in ack cycle", stall, 0);
    chk("ld stall cycles", n, 3);
    chk("ld wb not yet", wb_valid, 0);
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("ld wb_valid", wb_valid, 1);
    chk("ld wb_data", wb_data, 16'hBEEF);
    chk("ld req dropped", dmem_req, 0);
    tick();

    // Ack with no request outstanding is ignored.
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("stray ack stall", stall, 0);
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("stray ack wb_valid", wb_valid, 0);
    chk("stray ack req", dmem_req, 0);
    tick();

    // Flush while idle: instruction not accepted.
    drive(16'h0077, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    idle_ex(); flush = 1'b0;
    @(negedge clk);
    chk("flush idle wb_valid", wb_valid, 0);
    tick();

    // Flush during a load: bus read completes, writeback suppressed.
    drive(16'h0030, 16'h0000, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle_ex(); flush = 1'b1;
    @(negedge clk);
    chk("flush rd req", dmem_req, 1);
    tick();
    flush = 1'b0; dmem_ack = 1'b1; dmem_rdata = 16'h1111;
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("flush rd wb_valid", wb_valid, 1);
    chk("flush rd wb_en", wb_en, 0);
    tick();

    // Timeout: request held four cycles, then abort with sticky bus_err.
    drive(16'h0050, 16'h0000, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle_ex();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!dmem_req) break;
      n++;
    end
    chk("tmo req cycles", n, 4);
    chk("tmo bus_err", bus_err, 1);
    chk("tmo stall", stall, 0);
    chk("tmo wb_en", wb_en, 0);
    chk("tmo wb_valid", wb_valid, 0);
    tick();
    drive(16'h0042, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle_ex();
    @(negedge clk);
    chk("post tmo wb_data", wb_data, 16'h0042);
    chk("bus_err sticky", bus_err, 1);
    tick();

    // Reset during a word store drops the request on the next cycle.
    drive(16'h0060, 16'h0001, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle_ex();
    @(negedge clk);
    chk("wr req", dmem_req, 1);
    chk("wr we", dmem_we, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst mid wr req", dmem_req, 0);
    chk("rst mid wr stall", stall, 0);
    chk("rst clears bus_err", bus_err, 0);
    chk("rst mid wr wb_valid", wb_valid, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
